// File: rtl/digital_edge_generator.sv
// Register-configured delayed edge/pulse generator with an armed trigger FSM.
// Define DIGITAL_EDGE_GENERATOR_COUNT_EN to add the saturating fire counter.
module digital_edge_generator #(
    parameter int DELAY_W = 32,
    parameter int WIDTH_W = 16
) (
    input  logic        clk_usb,
    input  logic        reset,
    input  logic [7:0]  reg_cmd,
    input  logic [15:0] reg_bytecount,
    input  logic [7:0]  reg_data_in,
    output logic [7:0]  reg_data_out,
    input  logic        reg_read,
    input  logic        reg_write,
    input  logic        trigger_in,
    output logic        signal_out,
    output logic        busy
);
    localparam logic [7:0] CMD_CFG    = 8'h40;
    localparam logic [7:0] CMD_DELAY  = 8'h41;
    localparam logic [7:0] CMD_WIDTH  = 8'h42;
    localparam logic [7:0] CMD_STATUS = 8'h43;
    localparam logic [7:0] CMD_COUNT  = 8'h44;
    localparam int DELAY_B = DELAY_W / 8;
    localparam int WIDTH_B = WIDTH_W / 8;
    localparam int CNT_W   = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_DELAY, ST_PULSE} state_t;

    state_t               state_q, state_d;
    logic [7:0]           cfg_q, cfg_d;
    logic [DELAY_W-1:0]   delay_q, delay_d;
    logic [WIDTH_W-1:0]   width_q, width_d;
    logic [WIDTH_W-1:0]   wlat_q, wlat_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 sig_q;
    logic [31:0]          bidx;
    logic                 wr_cfg;
    logic [CNT_W-1:0]     len_now, len_lat;

`ifdef DIGITAL_EDGE_GENERATOR_COUNT_EN
    logic [15:0]          fire_cnt_q;
`endif

    assign bidx    = 32'(reg_bytecount);
    assign wr_cfg  = reg_write && (reg_cmd == CMD_CFG) && (bidx == 32'd0);
    // A zero width still produces a single-cycle pulse.
    assign len_now = (width_q == '0) ? CNT_W'(1) : CNT_W'(width_q);
    assign len_lat = (wlat_q == '0) ? CNT_W'(1) : CNT_W'(wlat_q);
    assign busy       = (state_q == ST_DELAY) || (state_q == ST_PULSE);
    assign signal_out = sig_q;

    always_comb begin
        delay_d = delay_q;
        width_d = width_q;
        for (int i = 0; i < DELAY_B; i++) begin
            if (reg_write && (reg_cmd == CMD_DELAY) && (bidx == 32'(i)))
                delay_d[i*8 +: 8] = reg_data_in;
        end
        for (int i = 0; i < WIDTH_B; i++) begin
            if (reg_write && (reg_cmd == CMD_WIDTH) && (bidx == 32'(i)))
                width_d[i*8 +: 8] = reg_data_in;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        wlat_d  = wlat_q;
        done_d  = done_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_q[1]) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (trigger_in) begin
                    // Width is captured here so later writes only affect the next firing.
                    wlat_d = width_q;
                    if (delay_q == '0) begin
                        state_d = ST_PULSE;
                        cnt_d   = len_now;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = CNT_W'(delay_q);
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_PULSE;
                    cnt_d   = len_lat;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == CNT_W'(1)) begin
                    done_d = 1'b1;
                    if (cfg_q[2]) begin
                        state_d = ST_ARMED;
                    end else begin
                        state_d  = ST_IDLE;
                        cfg_d[1] = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A CFG write wins over both trigger and pulse completion.
        if (wr_cfg) begin
            cfg_d  = reg_data_in;
            done_d = 1'b0;
            if (!reg_data_in[1]) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_ARMED) begin
                state_d = ST_ARMED;
                cnt_d   = cnt_q;
                wlat_d  = wlat_q;
            end
        end
    end

    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            delay_q <= '0;
            width_q <= '0;
            wlat_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sig_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            delay_q <= delay_d;
            width_q <= width_d;
            wlat_q  <= wlat_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sig_q   <= cfg_q[0] ^ (state_q == ST_PULSE);
        end
    end

`ifdef DIGITAL_EDGE_GENERATOR_COUNT_EN
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset)
            fire_cnt_q <= '0;
        else if (reg_write && (reg_cmd == CMD_COUNT))
            fire_cnt_q <= '0;
        else if ((state_d == ST_PULSE) && (state_q != ST_PULSE) && (fire_cnt_q != 16'hFFFF))
            fire_cnt_q <= fire_cnt_q + 16'd1;
    end
`endif

    always_comb begin
        reg_data_out = 8'd0;
        if (reg_read) begin
            case (reg_cmd)
                CMD_CFG: begin
                    if (bidx == 32'd0) reg_data_out = cfg_q;
                end
                CMD_DELAY: begin
                    for (int i = 0; i < DELAY_B; i++)
                        if (bidx == 32'(i)) reg_data_out = delay_q[i*8 +: 8];
                end
                CMD_WIDTH: begin
                    for (int i = 0; i < WIDTH_B; i++)
                        if (bidx == 32'(i)) reg_data_out = width_q[i*8 +: 8];
                end
                CMD_STATUS: begin
                    if (bidx == 32'd0) reg_data_out = {5'b0, done_q, busy, state_q == ST_ARMED};
                end
                CMD_COUNT: begin
`ifdef DIGITAL_EDGE_GENERATOR_COUNT_EN
                    if (bidx == 32'd0) reg_data_out = fire_cnt_q[7:0];
                    else if (bidx == 32'd1) reg_data_out = fire_cnt_q[15:8];
`endif
                end
                default: reg_data_out = 8'd0;
            endcase
        end
    end

endmodule

// File: doc/digital_edge_generator.md
DIGITAL_EDGE_GENERATOR -- requirements
Module: digital_edge_generator

Interface
REQ-001 SHALL have parameters: DELAY_W, 32, delay counter width in bits (multiple of 8); WIDTH_W, 16, pulse width counter width in bits (multiple of 8).
REQ-002 SHALL have a single clock and an asynchronous, active-high reset: clk_usb  in  1  sole clock for registers, FSM and output.
REQ-003 SHALL have port: reset  in  1  asynchronous active-high reset.
REQ-004 SHALL have ports: reg_cmd in 8 command; reg_bytecount in 16 byte index; reg_data_in in 8 write data; reg_data_out out 8 read data (combinational); reg_read in 1; reg_write in 1.
REQ-005 SHALL have ports: trigger_in in 1 synchronous trigger request; signal_out out 1 generated edge/pulse (registered); busy out 1 high in DELAY or PULSE.

Function
REQ-006 SHALL decode commands DIGITAL_EDGE_GENERATOR_CFG (1 byte), DIGITAL_EDGE_GENERATOR_DELAY (DELAY_W/8 bytes), DIGITAL_EDGE_GENERATOR_WIDTH (WIDTH_W/8 bytes) and DIGITAL_EDGE_GENERATOR_STATUS (1 byte, read-only), all defined in commands.v.
REQ-007 SHALL assemble multi-byte registers little-endian, with reg_bytecount selecting the byte; writes to out-of-range bytecount are ignored and reads return 8'd0.
REQ-008 SHALL use CFG bits: bit0 POL (0 = idle low/pulse high, 1 = idle high/pulse low); bit1 ARM; bit2 REARM (return to ARMED after a pulse); bits7:3 reserved, stored and read back.
REQ-009 SHALL return STATUS as {5'b0, done, busy, armed}; done is set when a pulse completes and cleared by any CFG write.
REQ-010 SHALL drive reg_data_out to 8'd0 whenever reg_read is low or reg_cmd is unrecognised.
REQ-011 SHALL implement FSM states IDLE, ARMED, DELAY and PULSE.
REQ-012 SHALL transition IDLE->ARMED on the clock edge after a CFG write with ARM=1.
REQ-013 SHALL, in ARMED, on an edge where trigger_in=1, load the delay counter from DELAY and go to DELAY, or go directly to PULSE when DELAY=0.
REQ-014 SHALL hold DELAY for exactly DELAY cycles, then load the width counter and go to PULSE.
REQ-015 SHALL assert signal_out active (= ~POL) for exactly max(WIDTH,1) cycles starting 1+DELAY cycles after the trigger-sampling edge.
REQ-016 SHALL, at the end of PULSE, set done and go to ARMED if REARM=1, else clear ARM and go to IDLE.
REQ-017 SHALL ignore trigger_in outside ARMED, including while busy, with no queuing.
REQ-018 SHALL let DELAY/WIDTH writes during DELAY or PULSE affect only the next firing; counters are loaded only on state entry.
REQ-019 SHALL abort to IDLE on a CFG write with ARM=0 in any state, with signal_out idle from the next edge.
REQ-020 SHALL apply a POL change on the next edge; signal_out is always POL XOR (state==PULSE), registered.
REQ-021 SHALL give a same-cycle CFG write priority over trigger_in.

Reset
REQ-022 SHALL, on reset assertion and independent of clk_usb: state IDLE; CFG, DELAY and WIDTH 0; done 0; busy 0; signal_out 0.
REQ-023 SHALL, on reset mid-DELAY or mid-PULSE, abort immediately with no completion and done left 0.

Configuration
REQ-024 SHALL, with DIGITAL_EDGE_GENERATOR_COUNT_EN defined, add a 16-bit saturating fire counter, incremented on each PULSE entry, read via DIGITAL_EDGE_GENERATOR_COUNT (2 bytes, little-endian), cleared by reset or any write to that command.
REQ-025 SHALL, without DIGITAL_EDGE_GENERATOR_COUNT_EN, have no counter logic, and reads of DIGITAL_EDGE_GENERATOR_COUNT SHALL return 8'd0.

Verification
REQ-026 SHALL pass: DELAY=5, WIDTH=3, POL=0, ARM=1, trigger at edge k -> signal_out high at edges k+6..k+8, then low; STATUS=8'h04; state IDLE.
REQ-027 SHALL pass: DELAY=0, WIDTH=0, POL=1 -> signal_out low for exactly 1 cycle beginning edge k+1.
REQ-028 SHALL pass: REARM=1, DELAY=2, WIDTH=2, 3 triggers spaced 10 cycles plus 1 trigger during busy -> exactly 3 pulses; COUNT=3 when COUNT_EN is defined.
REQ-029 SHALL pass: CFG write ARM=0 during PULSE -> signal_out idle on the next edge; STATUS=8'h00.
REQ-030 SHALL pass: reset asserted mid-DELAY between clock edges -> signal_out=0 and busy=0 immediately; all registers read back 0.
REQ-031 SHALL pass: DELAY write 32'h12345678 at bytecount 0..3 -> reads back 8'h78, 8'h56, 8'h34, 8'h12; bytecount 4 reads 8'h00.
